// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// Holds the measurement FSM state type and the tolerance arithmetic.
package div_mon_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [0:0] {
    WAIT_RISE = 1'b0,
    MEAS      = 1'b1
  } state_e;

  // Absolute difference with the operands ordered first so it never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus history flop for an asynchronous level input.
// Reports the synchronized level and single-cycle rise/fall strobes.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic level
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Next-state for the synchronizer chain.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchronizer and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;
  assign level = s2_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in sys_clock cycles,
// tracks lock against an expected ratio and flags a stalled input.
module clk_div_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_PERIOD = 5,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             sys_clock,
  input  logic             sys_rst_n,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout_err
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  TMO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_ONE = {{(GOOD_W-1){1'b0}}, 1'b1};

  logic rise_s, fall_s, unused_level_s;

  edge_sync u_edge_sync (
    .clk   (sys_clock),
    .rst_n (sys_rst_n),
    .d     (clk_in),
    .rise  (rise_s),
    .fall  (fall_s),
    .level (unused_level_s)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [CNT_W-1:0]  high_reg_q, high_reg_d;
  logic              fall_seen_q, fall_seen_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              meas_valid_q, meas_valid_d;
  logic              locked_q, locked_d;
  logic              timeout_q, timeout_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              meas_good_s;
  logic [31:0]       diff_s;

  // Judges the period that ends on the current rise.
  always_comb begin
    diff_s      = abs_diff(32'(cnt_q), 32'(EXP_PERIOD));
    meas_good_s = 1'b0;
    if ((diff_s <= 32'(TOL)) && fall_seen_q && (high_reg_q >= CNT_ONE)
        && (high_reg_q <= (cnt_q - CNT_ONE))) begin
      meas_good_s = 1'b1;
    end else begin
      meas_good_s = 1'b0;
    end
  end

  // Measurement FSM: next state, counters and output registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    high_reg_d   = high_reg_q;
    fall_seen_d  = fall_seen_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    timeout_d    = timeout_q;
    good_d       = good_q;

    case (state_q)
      WAIT_RISE: begin
        cnt_d = CNT_ZERO;
        if (rise_s) begin
          state_d     = MEAS;
          cnt_d       = CNT_ONE;
          fall_seen_d = 1'b0;
          idle_d      = CNT_ZERO;
        end else if (idle_q == TMO_VAL) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          good_d    = {GOOD_W{1'b0}};
          idle_d    = CNT_ONE;
        end else begin
          idle_d = (idle_q == CNT_MAX) ? idle_q : idle_q + CNT_ONE;
        end
      end

      MEAS: begin
        if (rise_s) begin
          // A rise always wins over a timeout landing in the same cycle.
          period_d     = cnt_q;
          high_d       = fall_seen_q ? high_reg_q : CNT_ZERO;
          meas_valid_d = 1'b1;
          cnt_d        = CNT_ONE;
          fall_seen_d  = 1'b0;
          timeout_d    = 1'b0;
          if (meas_good_s) begin
            good_d = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_ONE;
          end else begin
            good_d = {GOOD_W{1'b0}};
          end
          locked_d = (good_d == GOOD_MAX);
        end else if (cnt_q == TMO_VAL) begin
          state_d   = WAIT_RISE;
          cnt_d     = CNT_ZERO;
          idle_d    = CNT_ONE;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          good_d    = {GOOD_W{1'b0}};
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          if (fall_s) begin
            high_reg_d  = cnt_q;
            fall_seen_d = 1'b1;
          end else begin
            fall_seen_d = fall_seen_q;
          end
        end
      end

      default: begin
        state_d = WAIT_RISE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= WAIT_RISE;
      cnt_q        <= CNT_ZERO;
      idle_q       <= CNT_ZERO;
      high_reg_q   <= CNT_ZERO;
      fall_seen_q  <= 1'b0;
      period_q     <= CNT_ZERO;
      high_q       <= CNT_ZERO;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      good_q       <= {GOOD_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      high_reg_q   <= high_reg_d;
      fall_seen_q  <= fall_seen_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
      good_q       <= good_d;
    end
  end

  assign period_o    = period_q;
  assign high_o      = high_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios plus random clk_in waveforms,
// checked every cycle against a timestamp-based reference model.
module tb_clk_div_monitor;

  localparam int EXP   = 5;
  localparam int TOL   = 1;
  localparam int LOCKN = 4;
  localparam int TMO   = 255;

  logic       sys_clock = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       clk_in    = 1'b0;
  logic [7:0] period_o, high_o;
  logic       meas_valid, locked, timeout_err;

  clk_div_monitor dut (
    .sys_clock   (sys_clock),
    .sys_rst_n   (sys_rst_n),
    .clk_in      (clk_in),
    .period_o    (period_o),
    .high_o      (high_o),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .timeout_err (timeout_err)
  );

  always #5 sys_clock = ~sys_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: tracks edge timestamps of the clk_in copy the monitor sees
  // two sys_clock samples late, and derives each measurement from them.
  int t, t_rise, t_fall, t_idle, good;
  bit in_meas, fall_seen_m;
  bit h0, h1, h2;
  int e_period, e_high;
  bit e_valid, e_locked, e_tmo;

  task automatic model_reset();
    t = 0; t_rise = 0; t_fall = 0; t_idle = 0; good = 0;
    in_meas = 1'b0; fall_seen_m = 1'b0;
    h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    e_period = 0; e_high = 0; e_valid = 1'b0; e_locked = 1'b0; e_tmo = 1'b0;
  endtask

  task automatic model_step();
    bit lvl, prv, rise, fall, ok;
    int p, h;
    lvl = h1; prv = h2;
    h2 = h1; h1 = h0; h0 = clk_in;
    rise = lvl & ~prv;
    fall = ~lvl & prv;
    e_valid = 1'b0;
    if (in_meas) begin
      if (rise) begin
        p  = t - t_rise;
        h  = fall_seen_m ? (t_fall - t_rise) : 0;
        ok = (p >= EXP - TOL) && (p <= EXP + TOL) && fall_seen_m && (h >= 1) && (h <= p - 1);
        good = ok ? ((good < LOCKN) ? good + 1 : good) : 0;
        e_locked = (good == LOCKN);
        e_period = p; e_high = h; e_valid = 1'b1; e_tmo = 1'b0;
        t_rise = t; fall_seen_m = 1'b0;
      end else if (t - t_rise == TMO) begin
        e_tmo = 1'b1; e_locked = 1'b0; good = 0; in_meas = 1'b0; t_idle = t;
      end else if (fall) begin
        fall_seen_m = 1'b1; t_fall = t;
      end
    end else begin
      if (rise) begin
        in_meas = 1'b1; t_rise = t; fall_seen_m = 1'b0;
      end else if (t - t_idle == TMO) begin
        e_tmo = 1'b1; e_locked = 1'b0; good = 0; t_idle = t;
      end
    end
    t++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clock or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison shortly after each active edge.
  initial begin
    forever begin
      @(posedge sys_clock);
      #1;
      check_eq("period_o",    32'(period_o),    32'(e_period));
      check_eq("high_o",      32'(high_o),      32'(e_high));
      check_eq("meas_valid",  32'(meas_valid),  32'(e_valid));
      check_eq("locked",      32'(locked),      32'(e_locked));
      check_eq("timeout_err", 32'(timeout_err), 32'(e_tmo));
    end
  end

  task automatic drive(input int hi, input int lo);
    clk_in = 1'b1;
    repeat (hi) @(negedge sys_clock);
    clk_in = 1'b0;
    repeat (lo) @(negedge sys_clock);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_period"},  32'(period_o),    32'd0);
    check_eq({tag, "_high"},    32'(high_o),      32'd0);
    check_eq({tag, "_valid"},   32'(meas_valid),  32'd0);
    check_eq({tag, "_locked"},  32'(locked),      32'd0);
    check_eq({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    clk_in    = 1'b0;
    repeat (3) @(negedge sys_clock);
    check_all_zero("reset");
    sys_rst_n = 1'b1;

    // Divide-by-5, 3 high / 2 low.
    repeat (10) drive(3, 2);
    check_eq("div5_period", 32'(period_o), 32'd5);
    check_eq("div5_high",   32'(high_o),   32'd3);
    check_eq("div5_locked", 32'(locked),   32'd1);
    check_eq("div5_tmo",    32'(timeout_err), 32'd0);

    // Divide-by-7 never locks against an expected 5.
    repeat (8) drive(4, 3);
    check_eq("div7_period", 32'(period_o), 32'd7);
    check_eq("div7_high",   32'(high_o),   32'd4);
    check_eq("div7_locked", 32'(locked),   32'd0);

    // Periods 4, 6, 5, 6 all within tolerance.
    drive(2, 2); drive(3, 3); drive(3, 2); drive(4, 2); drive(3, 2);
    check_eq("alt_locked", 32'(locked),   32'd1);
    check_eq("alt_period", 32'(period_o), 32'd6);
    check_eq("alt_high",   32'(high_o),   32'd4);
    drive(4, 4); drive(3, 2);
    check_eq("p8_locked", 32'(locked),   32'd0);
    check_eq("p8_period", 32'(period_o), 32'd8);
    repeat (3) drive(3, 2);
    check_eq("relock_3good", 32'(locked), 32'd0);
    drive(3, 2);
    check_eq("relock_4good", 32'(locked), 32'd1);

    // Stall high until the timeout fires; the last measurement is held.
    clk_in = 1'b1;
    repeat (300) @(negedge sys_clock);
    check_eq("tmo_err",    32'(timeout_err), 32'd1);
    check_eq("tmo_locked", 32'(locked),      32'd0);
    check_eq("tmo_period", 32'(period_o),    32'd5);
    check_eq("tmo_high",   32'(high_o),      32'd3);
    clk_in = 1'b0;
    repeat (2) @(negedge sys_clock);
    repeat (3) drive(3, 2);
    check_eq("tmo_clear",  32'(timeout_err), 32'd0);
    check_eq("tmo_period2", 32'(period_o),   32'd5);
    check_eq("tmo_relock", 32'(locked),      32'd0);

    // Asynchronous reset in the middle of a locked period.
    repeat (6) drive(3, 2);
    check_eq("prerst_locked", 32'(locked), 32'd1);
    clk_in = 1'b1;
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(negedge sys_clock);
    clk_in    = 1'b0;
    sys_rst_n = 1'b1;
    repeat (4) drive(3, 2);
    check_eq("postrst_period", 32'(period_o), 32'd5);
    check_eq("postrst_high",   32'(high_o),   32'd3);

    // Short low glitch in the high phase breaks lock.
    repeat (2) drive(3, 2);
    check_eq("preglitch_locked", 32'(locked), 32'd1);
    drive(2, 1); drive(2, 2);
    check_eq("glitch_locked", 32'(locked),   32'd0);
    check_eq("glitch_period", 32'(period_o), 32'd3);
    check_eq("glitch_high",   32'(high_o),   32'd2);

    // Random waveforms, occasionally stalling long enough to time out.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 15))
        0:       drive(260 + int'($urandom_range(0, 20)), int'($urandom_range(1, 4)));
        1:       drive(int'($urandom_range(1, 4)), 260 + int'($urandom_range(0, 20)));
        default: drive(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
      endcase
    end
    repeat (5) @(negedge sys_clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
